// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and its single-bit shifter partner:
// controller state encoding and the amount-width helper.
`default_nettype none

package shift_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // One extra bit so that an amount equal to the data width is representable.
  function automatic int amount_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/single_bit_shifter.sv
// Single-bit shift/rotate engine with a programmable response latency; pairs with
// shift_sequencer through a start/finished handshake.
`default_nettype none

module single_bit_shifter #(
  parameter int N = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_left,
  input  logic         i_rotate,
  input  logic [N-1:0] i_value,
  input  logic [3:0]   i_latency,
  output logic         o_finished,
  output logic [N-1:0] o_value
);

  logic         busy;
  logic [3:0]   remaining;
  logic [N-1:0] result;
  logic [N-1:0] shifted;

  always_comb begin
    shifted = i_value;
    if (i_left)
      shifted = {i_value[N-2:0], (i_rotate ? i_value[N-1] : 1'b0)};
    else
      shifted = {(i_rotate ? i_value[0] : 1'b0), i_value[N-1:1]};
  end

  // A latency of 0 is treated as 1: the result is always presented after a register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      busy      <= 1'b0;
      remaining <= 4'd0;
      result    <= '0;
    end else if (busy) begin
      if (remaining == 4'd0)
        busy <= 1'b0;
      else
        remaining <= remaining - 4'd1;
    end else if (i_start) begin
      busy      <= 1'b1;
      remaining <= (i_latency == 4'd0) ? 4'd0 : i_latency - 4'd1;
      result    <= shifted;
    end
  end

  assign o_finished = busy && (remaining == 4'd0);
  assign o_value    = result;

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// Multi-bit shift/rotate sequencer: drives an external single-bit shifter once per
// requested step and reports the final value with a one-cycle finished pulse.
`default_nettype none

module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int N = 4,
  parameter int W = amount_width(N)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  output logic         o_finished,
  input  logic         i_left,
  input  logic         i_rotate,
  input  logic [W-1:0] i_amount,
  input  logic [N-1:0] i_value,
  output logic [N-1:0] o_value,
  output logic         o_sh_start,
  input  logic         i_sh_finished,
  output logic         o_sh_left,
  output logic         o_sh_rotate,
  output logic [N-1:0] o_sh_value,
  input  logic [N-1:0] i_sh_value
);

  logic [1:0]   state;
  logic [1:0]   next_state;
  logic [W-1:0] count;
  logic [N-1:0] work;
  logic         left_q;
  logic         rotate_q;
  logic [N-1:0] result;
  logic         last_step;

  assign last_step = (count == W'(1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (i_start)
          next_state = (i_amount == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (i_sh_finished)
          next_state = last_step ? ST_DONE : ST_ISSUE;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_sh_start = (state == ST_ISSUE);
    o_finished = (state == ST_DONE);
  end

  // Zero amounts never reach WAIT, so count is at least 1 whenever it decrements.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count    <= '0;
      work     <= '0;
      left_q   <= 1'b0;
      rotate_q <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_amount != '0) begin
              count    <= i_amount;
              work     <= i_value;
              left_q   <= i_left;
              rotate_q <= i_rotate;
            end else begin
              result <= i_value;
            end
          end
        end
        ST_WAIT: begin
          if (i_sh_finished) begin
            work  <= i_sh_value;
            count <= count - W'(1);
            if (last_step)
              result <= i_sh_value;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_value     = result;
  assign o_sh_left   = left_q;
  assign o_sh_rotate = rotate_q;
  assign o_sh_value  = work;

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter N, default 4, data width in bits.
REQ-002 Parameter W, default $clog2(N)+1, shift-amount width, so an amount of N is representable.
REQ-003 i_clock  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset  in  1  reset, asynchronous, active-low.
REQ-005 i_start  in  1  request pulse; sampled in IDLE only.
REQ-006 o_finished  out  1  one-cycle pulse; result on o_value valid.
REQ-007 i_left  in  1  1 = shift left, 0 = shift right; latched at start.
REQ-008 i_rotate  in  1  1 = rotate, 0 = logical shift; latched at start.
REQ-009 i_amount  in  W  number of single-bit steps; latched at start.
REQ-010 i_value  in  N  operand; latched at start.
REQ-011 o_value  out  N  result register.
REQ-012 o_sh_start  out  1  one-cycle request to the single-bit Shifter.
REQ-013 i_sh_finished  in  1  Shifter completion pulse.
REQ-014 o_sh_left, o_sh_rotate  out  1 each  latched direction and mode, held stable for the whole operation.
REQ-015 o_sh_value  out  N  operand for the current step; equals the working register.
REQ-016 i_sh_value  in  N  Shifter result, valid while i_sh_finished is high.

Function
REQ-017 The block shall be the initiator of the Shifter start/finished handshake; each Shifter transaction performs exactly one single-bit shift or rotate.
REQ-018 The block shall have four states: IDLE, ISSUE, WAIT, DONE.
REQ-019 In IDLE with i_start=1 and i_amount>0, the block shall latch all operands, load count=i_amount and work=i_value, and go to ISSUE.
REQ-020 In IDLE with i_start=1 and i_amount=0, the block shall load o_value=i_value, go to DONE, and issue no Shifter transaction.
REQ-021 ISSUE shall hold o_sh_start=1 for exactly one cycle, then go to WAIT.
REQ-022 In WAIT, when i_sh_finished=1, the block shall set work=i_sh_value and count=count-1; if the new count is 0 it shall set o_value=i_sh_value and go to DONE, otherwise it shall go to ISSUE.
REQ-023 WAIT shall have no timeout; the block waits indefinitely for i_sh_finished.
REQ-024 DONE shall hold o_finished=1 for exactly one cycle, then go to IDLE.
REQ-025 Latency shall be k*(L+1)+2 cycles from the i_start edge to the o_finished pulse, where k is the amount and L is the Shifter latency; amount 0 takes 2 cycles.
REQ-026 o_value shall hold its result until the next accepted start.
REQ-027 i_start outside IDLE shall be ignored, with no queuing.
REQ-028 i_sh_finished outside WAIT shall be ignored.
REQ-029 Amount >= N with logical mode shall execute all k steps, giving 0 for k>=N.
REQ-030 Rotate with amount N shall return the original value.
REQ-031 The count decrement shall never wrap, because the zero-amount path bypasses WAIT.

Reset
REQ-032 Asserting i_reset low shall immediately force state IDLE, o_finished=0, o_sh_start=0, o_value=0, count=0, work=0, and latched left/rotate=0.
REQ-033 Reset in the middle of an operation shall abandon it; a late i_sh_finished arriving after reset shall be ignored (REQ-028).
REQ-034 After reset is released, the first rising edge shall be able to accept i_start.

Structure
REQ-035 The state encoding localparams (2-bit IDLE=0, ISSUE=1, WAIT=2, DONE=3) shall live in the shared shifter package, together with the W-from-N width function.
REQ-036 The block shall have no sub-module; the Shifter is instantiated beside it by the integrating level or the bench.
REQ-037 The count and work registers shall be plain registers with no combinational path from i_sh_value to o_value.

Verification
REQ-038 Bench setup: pair the block with a single-bit Shifter, N=4.
REQ-039 Scenario, logical shift: value 4'b0011, left, logical, amount 2 -> exactly 2 o_sh_start pulses, o_value=4'b1100, one o_finished.
REQ-040 Scenario, rotate wrap: value 4'b1001, right, rotate, amount 4 -> 4 transactions, o_value=4'b1001.
REQ-041 Scenario, zero amount: value 4'b0110, amount 0 -> no o_sh_start, o_finished 2 cycles after start, o_value=4'b0110.
REQ-042 Scenario, over-shift: value 4'b1111, right, logical, amount 5 -> 5 transactions, o_value=4'b0000.
REQ-043 Scenario, reset mid-operation: i_reset low during the second WAIT, Shifter finishes later -> no o_finished, o_value=0, state IDLE; a new start is then accepted normally.
REQ-044 Scenario, busy ignore: i_start pulsed during WAIT with different operands -> the first operation completes unchanged, and the second start is not executed.
